dma_initiator: RTL

Bus-initiator copy engine for the femto peripheral bus. It is the requesting end of the bus that peripheral controllers such as the timer answer as responders. It accepts a single copy command from a control source (the CPU-side register block or the debug bridge). For each element it issues a read transaction followed by a write transaction, and it reports completion, or the first bus fault, back to the control source.

---
 rtl/dma_initiator_if.sv | 32 +++
 rtl/dma_initiator.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/dma_initiator_if.sv
// Femto peripheral bus bundle between a bus initiator and a responder.
// master: drives request/address/control/data; slave: returns read data, completion and fault.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_CNT
`define BUS_ACC_CNT 3
`endif

interface dma_initiator_if;
  logic [`XLEN-1:0]               p_addr;
  logic                           p_w_rb;
  logic [$clog2(`BUS_ACC_CNT)-1:0] p_acc;
  logic [`BUS_WIDTH-1:0]          p_wdata;
  logic [`BUS_WIDTH-1:0]          p_rdata;
  logic                           p_req;
  logic                           p_resp;
  logic                           p_fault;

  modport master (
    output p_addr, p_w_rb, p_acc, p_wdata, p_req,
    input  p_rdata, p_resp, p_fault
  );

  modport slave (
    input  p_addr, p_w_rb, p_acc, p_wdata, p_req,
    output p_rdata, p_resp, p_fault
  );
endinterface

// File: rtl/dma_initiator.sv
// Bus-initiator copy engine: per element one read then one write on the femto bus.
// Ports: clk/rstn, command (start,src,dst,len,acc,abort), status (busy,done,err), bus (master).
`ifndef XLEN
`define XLEN 32
`endif
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_CNT
`define BUS_ACC_CNT 3
`endif

module dma_initiator #(
  parameter int LEN_W = 16
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            start,
  input  logic [`XLEN-1:0]                src,
  input  logic [`XLEN-1:0]                dst,
  input  logic [LEN_W-1:0]                len,
  input  logic [$clog2(`BUS_ACC_CNT)-1:0] acc,
  input  logic                            abort,
  output logic                            busy,
  output logic                            done,
  output logic                            err,
  dma_initiator_if.master                 bus
);

  localparam int AW = $clog2(`BUS_ACC_CNT);
  localparam int XW = `XLEN;
  localparam int BW = `BUS_WIDTH;

  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

  state_t         state_q;
  logic [XW-1:0]  src_q, dst_q;
  logic [XW-1:0]  src_d, dst_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [AW-1:0]  acc_q;
  logic [BW-1:0]  data_q;
  logic           busy_q, done_q, err_q, errp_q;
  logic           req_q, wrb_q;
  logic [XW-1:0]  addr_q;
  logic [BW-1:0]  wdata_q;

  logic [XW-1:0]  step, amask;
  logic [BW-1:0]  rmask;
  logic           bad_cmd;

  always_comb begin
    step    = XW'(1) << acc_q;
    src_d   = src_q + step;
    dst_d   = dst_q + step;
    rem_d   = rem_q - LEN_W'(1);
    amask   = (XW'(1) << acc) - XW'(1);
    bad_cmd = (acc > AW'(2)) || (|((src | dst) & amask));
  end

  always_comb begin
    rmask = '1;
    unique case (acc_q)
      AW'(0):  rmask = BW'(8'hFF);
      AW'(1):  rmask = BW'(16'hFFFF);
      default: rmask = '1;
    endcase
  end

  // A response always drops p_req for one cycle; the following state
  // raises the next request (or reports in FIN) only after that gap.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      errp_q  <= 1'b0;
      req_q   <= 1'b0;
      wrb_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            src_q <= src;
            dst_q <= dst;
            rem_q <= len;
            acc_q <= acc;
            if (len == '0) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else if (bad_cmd) begin
              state_q <= FIN;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q <= RD;
              busy_q  <= 1'b1;
              req_q   <= 1'b1;
              wrb_q   <= 1'b0;
              addr_q  <= src;
            end
          end
        end
        RD: begin
          if (req_q && bus.p_resp) begin
            req_q <= 1'b0;
            if (bus.p_fault) begin
              state_q <= FIN;
              errp_q  <= 1'b1;
            end else begin
              data_q  <= bus.p_rdata & rmask;
              state_q <= WR;
            end
          end else if (!req_q) begin
            req_q  <= 1'b1;
            wrb_q  <= 1'b0;
            addr_q <= src_q;
          end
        end
        WR: begin
          if (req_q && bus.p_resp) begin
            req_q <= 1'b0;
            if (bus.p_fault) begin
              state_q <= FIN;
              errp_q  <= 1'b1;
            end else begin
              src_q <= src_d;
              dst_q <= dst_d;
              rem_q <= rem_d;
              if (rem_d == '0) begin
                state_q <= FIN;
                errp_q  <= 1'b0;
              end else if (abort) begin
                state_q <= FIN;
                errp_q  <= 1'b1;
              end else begin
                state_q <= RD;
              end
            end
          end else if (!req_q) begin
            req_q   <= 1'b1;
            wrb_q   <= 1'b1;
            addr_q  <= dst_q;
            wdata_q <= data_q;
          end
        end
        FIN: begin
          // busy still high: this is the bus gap cycle, report next.
          if (busy_q) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            err_q  <= errp_q;
            errp_q <= 1'b0;
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign bus.p_addr  = addr_q;
  assign bus.p_w_rb  = wrb_q;
  assign bus.p_acc   = acc_q;
  assign bus.p_wdata = wdata_q;
  assign bus.p_req   = req_q;

endmodule
